// File: rtl/lsu.sv
// Load/store unit: one RV32 load or store per request over a single-outstanding
// memory handshake. Misaligned or unsupported ops raise an exception without
// touching the bus, and a stalled bus is converted into an access fault.
module lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            resp_valid,
  output logic            resp_we,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            exc_valid,
  output logic [1:0]      exc_code,
  output logic [XLEN-1:0] exc_addr
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_we_q, resp_we_d;
  logic [4:0]      resp_rd_q, resp_rd_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            exc_valid_q, exc_valid_d;
  logic [1:0]      exc_code_q, exc_code_d;
  logic [XLEN-1:0] exc_addr_q, exc_addr_d;

  logic            mis;
  logic [3:0]      st_wstrb;
  logic [31:0]     st_wdata;
  logic [31:0]     ld_sh;
  logic [XLEN-1:0] ld_data;
  logic            tmo_hit;

  assign req_ready  = (state_q == IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_we    = resp_we_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
  assign exc_valid  = exc_valid_q;
  assign exc_code   = exc_code_q;
  assign exc_addr   = exc_addr_q;

  // Alignment / legality of the incoming op; unsupported encodings count as misaligned
  always_comb begin
    mis = 1'b1;
    case (req_funct3)
      3'b000:  mis = 1'b0;
      3'b001:  mis = req_addr[0];
      3'b010:  mis = |req_addr[1:0];
      3'b100,
      3'b101:  mis = req_we ? 1'b1 : ((req_funct3[0]) ? req_addr[0] : 1'b0);
      default: mis = 1'b1;
    endcase
  end

  // Store lane replication and byte enables from the incoming request
  always_comb begin
    st_wdata = req_wdata[31:0];
    st_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
    if (!req_we) st_wstrb = 4'b0000;
  end

  // Load byte/half extraction with sign or zero extension
  always_comb begin
    ld_sh   = mem_rdata >> {off_q, 3'b000};
    ld_data = XLEN'(ld_sh);
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_data = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
      default: ;
    endcase
  end

  // Last wait cycle before an access fault; ack in this cycle still wins
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and output register logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_we_d    = resp_we_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    exc_valid_d  = 1'b0;
    exc_code_d   = exc_code_q;
    exc_addr_d   = exc_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (mis) begin
            exc_valid_d = 1'b1;
            exc_code_d  = {1'b0, req_we};
            exc_addr_d  = req_addr;
          end else begin
            state_d     = BUS;
            cnt_d       = '0;
            we_d        = req_we;
            f3_d        = req_funct3;
            off_d       = req_addr[1:0];
            rd_d        = req_rd;
            addr_d      = req_addr;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_wstrb_d = st_wstrb;
            mem_wdata_d = st_wdata;
          end
        end
      end
      BUS: begin
        if (mem_ack) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          resp_we_d    = we_q;
          resp_rd_d    = rd_q;
          resp_data_d  = we_q ? '0 : ld_data;
        end else if (tmo_hit) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          exc_valid_d = 1'b1;
          exc_code_d  = {1'b1, we_q};
          exc_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      addr_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rd_q    <= 5'd0;
      resp_data_q  <= '0;
      exc_valid_q  <= 1'b0;
      exc_code_q   <= 2'b00;
      exc_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      exc_valid_q  <= exc_valid_d;
      exc_code_q   <= exc_code_d;
      exc_addr_q   <= exc_addr_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected responses/exceptions,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        resp_valid, resp_we, exc_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data, exc_addr;
  logic [1:0]  exc_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        exc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  code;
    logic [31:0] addr;
  } exp_t;
  exp_t sb[$];

  lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every response/exception pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (resp_valid || exc_valid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1'b0, {resp_valid, exc_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.exc)
          chk("exc", exc_valid && !resp_valid && exc_code == e.code && exc_addr == e.addr,
              {exc_code, exc_addr[29:0]}, {e.code, e.addr[29:0]});
        else
          chk("resp", resp_valid && !exc_valid && resp_we == e.we && resp_rd == e.rd && resp_data == e.data,
              resp_data, e.data);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Aligned op: wait_n idle bus cycles, then ack; checks bus fields every BUS cycle
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input int wait_n,
                       input logic [31:0] rdata, input logic [3:0] ewstrb,
                       input logic [31:0] ewdata, input logic [31:0] edata);
    exp_t e;
    e.exc = 1'b0; e.we = we; e.rd = rd; e.data = edata; e.code = 2'b00; e.addr = 32'd0;
    sb.push_back(e);
    issue(we, f3, a, wd, rd);
    for (int i = 0; i <= wait_n; i++) begin
      if (i == wait_n) begin mem_ack = 1'b1; mem_rdata = rdata; end
      @(negedge clk);
      chk("bus", mem_req && mem_we == we && mem_addr == {a[31:2], 2'b00} &&
          mem_wstrb == ewstrb && (!we || mem_wdata == ewdata),
          {mem_wstrb, mem_addr[27:0]}, {ewstrb, a[27:2], 2'b00});
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    chk("resp_lat", resp_valid, {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic mis_op(input logic we, input logic [2:0] f3, input logic [31:0] a);
    exp_t e;
    e.exc = 1'b1; e.we = we; e.rd = 5'd0; e.data = 32'd0; e.code = {1'b0, we}; e.addr = a;
    sb.push_back(e);
    issue(we, f3, a, 32'h0, 5'd0);
    @(negedge clk);
    chk("mis_nobus", !mem_req && req_ready && exc_valid, {mem_req, req_ready, exc_valid}, 32'b011);
  endtask

  initial begin
    int cnt;
    exp_t e;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #2;
    chk("reset_outs", !mem_req && !mem_we && mem_wstrb == 0 && mem_addr == 0 && mem_wdata == 0 &&
        !resp_valid && !resp_we && resp_rd == 0 && resp_data == 0 && !exc_valid &&
        exc_code == 0 && exc_addr == 0, {mem_req, resp_valid, exc_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, {31'd0, req_ready}, 32'd1);

    // Loads
    do_op(1'b0, 3'b010, 32'h1000, 32'h0, 5'd5,  0, 32'hDEADBEEF, 4'b0000, 32'h0, 32'hDEADBEEF);
    do_op(1'b0, 3'b000, 32'h1003, 32'h0, 5'd6,  0, 32'h80112233, 4'b0000, 32'h0, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h1003, 32'h0, 5'd7,  0, 32'h80112233, 4'b0000, 32'h0, 32'h00000080);
    do_op(1'b0, 3'b001, 32'h1002, 32'h0, 5'd8,  0, 32'h80112233, 4'b0000, 32'h0, 32'hFFFF8011);
    do_op(1'b0, 3'b101, 32'h1000, 32'h0, 5'd9,  1, 32'h80118233, 4'b0000, 32'h0, 32'h00008233);
    // Stores
    do_op(1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 5'd0, 3, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    do_op(1'b1, 3'b000, 32'h2001, 32'h12345678, 5'd0, 0, 32'h0, 4'b0010, 32'h78787878, 32'h0);
    do_op(1'b1, 3'b010, 32'h3000, 32'hCAFEF00D, 5'd0, 0, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);
    // Misaligned / unsupported
    mis_op(1'b0, 3'b010, 32'h1001);
    mis_op(1'b1, 3'b010, 32'h3002);
    mis_op(1'b0, 3'b011, 32'h4000);
    mis_op(1'b1, 3'b100, 32'h4000);

    // Timeout on a store with no ack
    e.exc = 1'b1; e.we = 1'b1; e.rd = 5'd0; e.data = 32'd0; e.code = 2'd3; e.addr = 32'h5004;
    sb.push_back(e);
    issue(1'b1, 3'b010, 32'h5004, 32'h11111111, 5'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      cnt++;
    end
    chk("tmo_req_cycles", cnt == 4, cnt, 32'd4);
    @(posedge clk); #1; mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", !resp_valid && !exc_valid && req_ready, {resp_valid, exc_valid}, 32'd0);

    // Ack arriving in the cycle the timeout would fire
    do_op(1'b1, 3'b010, 32'h5008, 32'h22222222, 5'd0, 3, 32'h0, 4'b1111, 32'h22222222, 32'h0);

    // Reset while in BUS
    issue(1'b0, 3'b010, 32'h6000, 32'h0, 5'd3);
    @(negedge clk);
    chk("bus_before_rst", mem_req, {31'd0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_drops_req", !mem_req, {31'd0, mem_req}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("ready_after_midrst", req_ready && !mem_req, {req_ready, mem_req}, 32'b10);

    chk("sb_drained", sb.size() == 0, sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
